fan_ctrl: RTL and testbench

FAN_CTRL -- requirements
Module: fan_ctrl

---
 rtl/fan_ctrl.sv | 152 +++++++++++++++
 tb/tb_fan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fan_ctrl.sv
// Fan PWM controller: CSR block (CTRL/DUTY/STATUS), prescaled 8-bit PWM with
// per-period duty shadow, kick-start FSM and tacho-based stall monitor.
module fan_ctrl #(
  parameter logic [4:0] BASE_ADDR = 5'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       ce_tick,
  input  logic       ce_1hz,
  input  logic       tacho_pulse,
  output logic       pwm_out
);
  localparam logic [4:0] A_CTRL = BASE_ADDR;
  localparam logic [4:0] A_DUTY = BASE_ADDR + 5'd1;
  localparam logic [4:0] A_STAT = BASE_ADDR + 5'd2;

  typedef enum logic [1:0] {S_OFF = 2'b00, S_KICK = 2'b01, S_RUN = 2'b10} state_e;

  state_e     state_q, state_d;
  logic       en_q, en_d, ak_q, ak_d;
  logic [1:0] presc_q, presc_d;
  logic [7:0] duty_q, duty_d, shadow_q, shadow_d, cnt_q, cnt_d;
  logic [2:0] pdiv_q, pdiv_d, pmask;
  logic [1:0] kick_q, kick_d;
  logic       stall_q, stall_d, seen_q, seen_d, armed_q, armed_d, pwm_q, pwm_d;
  logic       wr_ctrl, wr_duty, wr_stat, step, mon_act, stall_set, enter_run;

  assign wr_ctrl = csr_we && (csr_a == A_CTRL);
  assign wr_duty = csr_we && (csr_a == A_DUTY);
  assign wr_stat = csr_we && (csr_a == A_STAT);

  always_comb begin
    case (presc_q)
      2'd0:    pmask = 3'b000;
      2'd1:    pmask = 3'b001;
      2'd2:    pmask = 3'b011;
      default: pmask = 3'b111;
    endcase
  end

  assign step      = (state_q == S_RUN) && ce_tick && ((pdiv_q & pmask) == pmask);
  assign mon_act   = (state_q == S_RUN) && (shadow_q != 8'h00);
  assign stall_set = mon_act && ce_1hz && armed_q && !seen_q && !tacho_pulse;

  // Transitions follow the registered CTRL, so a CTRL write takes effect one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:   if (en_q) state_d = ak_q ? S_KICK : S_RUN;
      S_KICK:  if (!en_q) state_d = S_OFF;
               else if (kick_q == 2'd2) state_d = S_RUN;
      S_RUN:   if (!en_q) state_d = S_OFF;
               else if (stall_set && ak_q) state_d = S_KICK;
      default: state_d = S_OFF;
    endcase
  end

  assign enter_run = (state_d == S_RUN) && (state_q != S_RUN);

  always_comb begin
    en_d     = en_q;
    ak_d     = ak_q;
    presc_d  = presc_q;
    duty_d   = duty_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    pdiv_d   = pdiv_q;
    kick_d   = 2'd0;
    seen_d   = 1'b0;
    armed_d  = 1'b0;
    if (wr_ctrl) begin
      en_d    = csr_di[7];
      ak_d    = csr_di[6];
      presc_d = csr_di[1:0];
    end
    if (wr_duty) duty_d = csr_di;
    // Set wins over a same-cycle write-1-to-clear.
    stall_d = stall_set | (stall_q & ~(wr_stat & csr_di[0]));
    // Only strobes seen while already in KICK count; the entry-cycle strobe is dropped.
    if (state_q == S_KICK)
      kick_d = (ce_1hz && kick_q != 2'd2) ? kick_q + 2'd1 : kick_q;
    if (state_q != S_RUN) begin
      cnt_d  = 8'h00;
      pdiv_d = 3'd0;
    end else if (ce_tick) begin
      pdiv_d = pdiv_q + 3'd1;
      if (step) cnt_d = cnt_q + 8'd1;
    end
    if (enter_run || (step && cnt_q == 8'hFF)) shadow_d = duty_q;
    if (mon_act) begin
      if (ce_1hz) begin
        seen_d  = 1'b0;
        armed_d = 1'b1;
      end else begin
        seen_d  = seen_q | tacho_pulse;
        armed_d = armed_q;
      end
    end
    case (state_q)
      S_RUN:   pwm_d = (cnt_q < shadow_q);
      S_KICK:  pwm_d = 1'b1;
      default: pwm_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      en_q     <= 1'b0;
      ak_q     <= 1'b0;
      presc_q  <= 2'd0;
      duty_q   <= 8'h00;
      shadow_q <= 8'h00;
      cnt_q    <= 8'h00;
      pdiv_q   <= 3'd0;
      kick_q   <= 2'd0;
      stall_q  <= 1'b0;
      seen_q   <= 1'b0;
      armed_q  <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      ak_q     <= ak_d;
      presc_q  <= presc_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      pdiv_q   <= pdiv_d;
      kick_q   <= kick_d;
      stall_q  <= stall_d;
      seen_q   <= seen_d;
      armed_q  <= armed_d;
      pwm_q    <= pwm_d;
    end
  end

  always_comb begin
    case (csr_a)
      A_CTRL:  csr_do = {en_q, ak_q, 4'b0000, presc_q};
      A_DUTY:  csr_do = duty_q;
      A_STAT:  csr_do = {5'b00000, state_q, stall_q};
      default: csr_do = 8'h00;
    endcase
  end

  assign pwm_out = pwm_q;
endmodule

// File: tb/tb_fan_ctrl.sv
// Directed bench for fan_ctrl: stimulus pushes expected values into a queue and
// a negedge monitor pops and compares whenever an observation is presented.
module tb_fan_ctrl;
  logic       clk, rst, csr_we, ce_tick, ce_1hz, tacho_pulse, pwm_out;
  logic [4:0] csr_a;
  logic [7:0] csr_di, csr_do;

  typedef struct {
    string name;
    int    kind;   // 0: csr_do, 1: measured value, 2: pwm_out level
    int    exp;
  } item_t;

  item_t q[$];
  logic  obs_vld;
  int    meas;
  int    total, bad;

  fan_ctrl #(.BASE_ADDR(5'h0)) dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .ce_tick(ce_tick), .ce_1hz(ce_1hz),
    .tacho_pulse(tacho_pulse), .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (obs_vld) begin : mon
      item_t it;
      int    act;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: observation with no expected value");
      end else begin
        it = q.pop_front();
        case (it.kind)
          0:       act = int'(csr_do);
          1:       act = meas;
          default: act = int'(pwm_out);
        endcase
        if (act != it.exp) begin
          bad++;
          $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", it.name, act, act, it.exp, it.exp);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic obs(input string nm, input int kind, input int e);
    item_t it;
    it.name = nm; it.kind = kind; it.exp = e;
    q.push_back(it);
    obs_vld = 1'b1;
    cyc(1);
    obs_vld = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    cyc(1);
    csr_we = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input int e);
    csr_a = a;
    obs(nm, 0, e);
  endtask

  task automatic chk_meas(input string nm, input int e, input int act);
    meas = act;
    obs(nm, 1, e);
  endtask

  task automatic hz();
    ce_1hz = 1'b1; cyc(1); ce_1hz = 1'b0;
  endtask

  task automatic tacho();
    tacho_pulse = 1'b1; cyc(1); tacho_pulse = 1'b0;
  endtask

  task automatic find_rise();
    logic prev;
    bit   ok;
    prev = pwm_out; ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      cyc(1);
      if (pwm_out && !prev) begin ok = 1'b1; break; end
      prev = pwm_out;
    end
    if (!ok) chk_meas("rise_timeout", 1, 0);
  endtask

  // Two back-to-back periods from a rise; optional DUTY write at sample wr_at.
  task automatic period_run(input int wr_at, input logic [7:0] wd, output int h0, output int h1);
    h0 = 0; h1 = 0;
    for (int i = 0; i < 512; i++) begin
      if (i < 256) h0 += int'(pwm_out); else h1 += int'(pwm_out);
      csr_a = 5'd1; csr_di = wd; csr_we = (i == wr_at);
      cyc(1);
      csr_we = 1'b0;
    end
  endtask

  task automatic count_hi(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin h += int'(pwm_out); cyc(1); end
  endtask

  task automatic period_meas(output int n, output int h);
    logic prev;
    n = 0; h = 0;
    while (n < 5000) begin
      h += int'(pwm_out); n++;
      prev = pwm_out;
      cyc(1);
      if (pwm_out && !prev) break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, n;
    total = 0; bad = 0; meas = 0; obs_vld = 1'b0;
    rst = 1'b1; csr_a = 5'd0; csr_di = 8'h00; csr_we = 1'b0;
    ce_tick = 1'b0; ce_1hz = 1'b0; tacho_pulse = 1'b0;
    cyc(3);
    rst = 1'b0;
    ce_tick = 1'b1;

    rd("rst_ctrl", 5'd0, 8'h00);
    rd("rst_duty", 5'd1, 8'h00);
    rd("rst_status", 5'd2, 8'h00);
    obs("rst_pwm", 2, 0);

    wr(5'd0, 8'h3C); rd("ctrl_rsvd_bits", 5'd0, 8'h00);
    wr(5'd0, 8'h43); rd("ctrl_readback", 5'd0, 8'h43);
    wr(5'd0, 8'h00);
    wr(5'd1, 8'h40); rd("duty_readback", 5'd1, 8'h40);
    rd("unmapped_addr", 5'd3, 8'h00);
    wr(5'd2, 8'hFE); rd("status_ro_bits", 5'd2, 8'h00);

    // Plain RUN, duty 64/256
    wr(5'd0, 8'h80); cyc(3);
    rd("run_status", 5'd2, 8'h04);
    find_rise();
    period_run(-1, 8'h40, h0, h1);
    chk_meas("duty40_p0", 64, h0);
    chk_meas("duty40_p1", 64, h1);

    // Mid-period DUTY write only affects the following period
    find_rise();
    period_run(9, 8'hC0, h0, h1);
    chk_meas("midwrite_cur", 64, h0);
    chk_meas("midwrite_next", 192, h1);

    // Kick-start
    wr(5'd0, 8'h00); cyc(3);
    rd("off_status", 5'd2, 8'h00);
    obs("off_pwm", 2, 0);
    wr(5'd0, 8'hC0); cyc(2);
    rd("kick_status", 5'd2, 8'h02);
    obs("kick_pwm", 2, 1);
    hz(); cyc(2);
    rd("kick_after_1hz", 5'd2, 8'h02);
    obs("kick_pwm2", 2, 1);
    hz(); cyc(3);
    rd("kick_to_run", 5'd2, 8'h04);

    // Stall with auto-kick
    hz();
    wr(5'd1, 8'h80);
    tacho(); hz();
    rd("tacho_no_stall", 5'd2, 8'h04);
    hz(); cyc(1);
    rd("stall_autokick", 5'd2, 8'h03);
    wr(5'd2, 8'h01);
    rd("stall_w1c", 5'd2, 8'h02);

    // Stall without auto-kick, coincident with W1C
    wr(5'd0, 8'h00); cyc(3);
    wr(5'd0, 8'h80); cyc(3);
    rd("run_noak", 5'd2, 8'h04);
    hz(); cyc(2);
    csr_a = 5'd2; csr_di = 8'h01; csr_we = 1'b1; ce_1hz = 1'b1;
    cyc(1);
    csr_we = 1'b0; ce_1hz = 1'b0;
    cyc(1);
    rd("stall_vs_w1c", 5'd2, 8'h05);
    wr(5'd2, 8'h01);
    rd("stall_cleared", 5'd2, 8'h04);

    // Duty extremes
    wr(5'd1, 8'h00); cyc(600);
    count_hi(300, h0);
    chk_meas("duty00", 0, h0);
    wr(5'd1, 8'hFF); cyc(300);
    find_rise();
    count_hi(256, h0);
    chk_meas("dutyFF", 255, h0);

    // Prescaler /8: 2048-tick period
    wr(5'd1, 8'h80);
    wr(5'd0, 8'h83);
    find_rise();
    period_meas(n, h0);
    chk_meas("presc3_period", 2048, n);
    chk_meas("presc3_high", 1024, h0);

    // Reset in the middle of KICK
    wr(5'd0, 8'h00); cyc(3);
    wr(5'd0, 8'hC3); cyc(3);
    rd("prerst_kick", 5'd2, 8'h02);
    rst = 1'b1; cyc(1); rst = 1'b0;
    obs("midrst_pwm", 2, 0);
    rd("midrst_ctrl", 5'd0, 8'h00);
    rd("midrst_duty", 5'd1, 8'h00);
    rd("midrst_status", 5'd2, 8'h00);

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
